// File: rtl/aes_uart_sequencer.sv
// aes_uart_sequencer
// Byte-level command sequencer between a UART RX/TX pair and an AES core.
// Frames are one command byte ('K' = key, 'P' = plaintext + encrypt) followed
// by 16 payload bytes, MSB byte first. After an encryption, the 16 ciphertext
// bytes are streamed back through the UART transmitter, MSB byte first.
//
// Optional feature macro: SCA_TRIGGER_EN
//   defined   -> trigger is a registered scope window that opens with aes_start
//                and closes the cycle after aes_ready is latched.
//   undefined -> trigger is tied low and no trigger register exists.
//
// Reset is synchronous and active-low.

module aes_uart_sequencer #(
  parameter int          RX_TIMEOUT = 100000,
  parameter logic [7:0]  ACK_BYTE   = 8'h06
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_done,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_done,
  output logic         aes_start,
  input  logic         aes_ready,
  output logic [127:0] pt_to_aes,
  input  logic [127:0] ct_from_aes,
  output logic [127:0] new_key,
  output logic         key_write_en,
  output logic         busy,
  output logic         trigger
);

  localparam logic [7:0]  CMD_KEY  = 8'h4B;
  localparam logic [7:0]  CMD_PT   = 8'h50;
  localparam logic [31:0] TMO_LAST = 32'(RX_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    RX_KEY,
    RX_PT,
    KEY_WR,
    ACK,
    START,
    WAIT,
    TX_LOAD,
    TX_WAIT
  } state_t;

  state_t         state;
  logic [127:0]   asm_reg;
  logic [127:0]   ct_sr;
  logic [3:0]     byte_cnt;
  logic [4:0]     tx_cnt;
  logic [31:0]    tmo_cnt;
  logic [127:0]   asm_next;

`ifdef SCA_TRIGGER_EN
  logic           trig_q;
  assign trigger = trig_q;
`else
  assign trigger = 1'b0;
`endif

  // The assembly register with the current received byte shifted in at the bottom.
  assign asm_next = {asm_reg[119:0], rx_data};

  // Single sequencer FSM: frame parsing, commit, encryption handshake and ciphertext streaming.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      asm_reg      <= 128'h0;
      ct_sr        <= 128'h0;
      byte_cnt     <= 4'd0;
      tx_cnt       <= 5'd0;
      tmo_cnt      <= 32'd0;
      tx_data      <= 8'h00;
      tx_start     <= 1'b0;
      aes_start    <= 1'b0;
      key_write_en <= 1'b0;
      busy         <= 1'b0;
      pt_to_aes    <= 128'h0;
      new_key      <= 128'h0;
`ifdef SCA_TRIGGER_EN
      trig_q       <= 1'b0;
`endif
    end else begin
      tx_start     <= 1'b0;
      aes_start    <= 1'b0;
      key_write_en <= 1'b0;

      case (state)
        IDLE: begin
          byte_cnt <= 4'd0;
          tmo_cnt  <= 32'd0;
          busy     <= 1'b0;
          if (rx_done) begin
            if (rx_data == CMD_KEY) begin
              state <= RX_KEY;
              busy  <= 1'b1;
            end else if (rx_data == CMD_PT) begin
              state <= RX_PT;
              busy  <= 1'b1;
            end
          end
        end

        RX_KEY, RX_PT: begin
          if (rx_done) begin
            asm_reg  <= asm_next;
            byte_cnt <= byte_cnt + 4'd1;
            tmo_cnt  <= 32'd0;
            if (byte_cnt == 4'd15) begin
              if (state == RX_KEY) begin
                state        <= KEY_WR;
                new_key      <= asm_next;
                key_write_en <= 1'b1;
              end else begin
                state     <= START;
                pt_to_aes <= asm_next;
                aes_start <= 1'b1;
`ifdef SCA_TRIGGER_EN
                trig_q    <= 1'b1;
`endif
              end
            end
          end else if (tmo_cnt >= TMO_LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            byte_cnt <= 4'd0;
            tmo_cnt  <= 32'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        KEY_WR: begin
          tx_data  <= ACK_BYTE;
          tx_start <= 1'b1;
          state    <= ACK;
        end

        ACK: begin
          if (tx_done && !tx_start) begin
            state    <= IDLE;
            busy     <= 1'b0;
            byte_cnt <= 4'd0;
          end
        end

        START: begin
          tx_cnt <= 5'd0;
          state  <= WAIT;
        end

        WAIT: begin
          if (aes_ready) begin
            ct_sr  <= ct_from_aes;
            state  <= TX_LOAD;
`ifdef SCA_TRIGGER_EN
            trig_q <= 1'b0;
`endif
          end
        end

        TX_LOAD: begin
          tx_data  <= ct_sr[127:120];
          ct_sr    <= {ct_sr[119:0], 8'h00};
          tx_start <= 1'b1;
          tx_cnt   <= tx_cnt + 5'd1;
          state    <= TX_WAIT;
        end

        TX_WAIT: begin
          // The next byte is launched straight from the tx_done edge so it
          // follows the previous one with a single cycle of latency; a tx_done
          // coinciding with our own start request cannot belong to that byte.
          if (tx_done && !tx_start) begin
            if (tx_cnt == 5'd16) begin
              state    <= IDLE;
              busy     <= 1'b0;
              byte_cnt <= 4'd0;
            end else begin
              tx_data  <= ct_sr[127:120];
              ct_sr    <= {ct_sr[119:0], 8'h00};
              tx_start <= 1'b1;
              tx_cnt   <= tx_cnt + 5'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_uart_sequencer.md
# aes_uart_sequencer

Byte-level command sequencer between the UART receiver/transmitter pair and the AES core in the SCA11 test chip. It parses framed commands arriving as received bytes and loads either a new 128-bit key or a 128-bit plaintext. After a plaintext load it starts one encryption, waits for the core, and streams the 16 ciphertext bytes back through the UART transmitter. It also produces a scope trigger window around the encryption for side-channel capture.

## Interface
Parameters:
- RX_TIMEOUT, 100000: clock cycles allowed between consecutive bytes inside a frame before the frame is aborted.
- ACK_BYTE, 8'h06: byte transmitted after a successful key load.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- rx_data  in  8  received byte; valid only while rx_done is high.
- rx_done  in  1  one-cycle pulse from the UART receiver.
- tx_data  out  8  byte to the UART transmitter.
- tx_start  out  1  one-cycle request to the UART transmitter.
- tx_done  in  1  one-cycle pulse from the UART transmitter (tx_done_flag).
- aes_start  out  1  one-cycle encryption start pulse.
- aes_ready  in  1  level; high when ct_from_aes is valid.
- pt_to_aes  out  128  plaintext to the core. The first payload byte is bits [127:120].
- ct_from_aes  in  128  ciphertext from the core.
- new_key  out  128  key to the core. Uses the same byte order as pt_to_aes.
- key_write_en  out  1  one-cycle key write strobe.
- busy  out  1  high in every state except IDLE.
- trigger  out  1  SCA capture window (see Configuration).

## Operation
- Frame format: one command byte followed by 16 payload bytes.
  - Command 8'h4B ('K') loads the key.
  - Command 8'h50 ('P') loads the plaintext and runs an encryption.
  - Any other command byte in IDLE is discarded and the state stays IDLE.
- Payload bytes shift into a private 128-bit assembly register, MSB byte first.
  - pt_to_aes and new_key change only on commit, never during assembly.
- States:
  - IDLE: wait for a command byte.
  - RX_KEY: collect key payload.
  - RX_PT: collect plaintext payload.
  - KEY_WR: commit key.
  - ACK: send ACK_BYTE.
  - START: start encryption.
  - WAIT: wait for the AES core.
  - TX_LOAD: present next ciphertext byte.
  - TX_WAIT: wait for transmitter completion.
- A 4-bit byte_cnt counts payload bytes. It clears on entry to RX_KEY or RX_PT and on every return to IDLE.
- RX_KEY → KEY_WR on the 16th rx_done.
  - KEY_WR: new_key ← assembly register; key_write_en = 1 for exactly that cycle.
  - Then ACK: tx_data = ACK_BYTE with a tx_start pulse; wait for tx_done; then IDLE.
- RX_PT → START on the 16th rx_done.
  - START: pt_to_aes ← assembly register; aes_start = 1 for exactly that cycle.
  - Then WAIT.
- WAIT: the first cycle after START in which aes_ready = 1 latches ct_from_aes into the output shift register, then goes to TX_LOAD.
  - aes_ready in the START cycle itself is ignored.
- TX_LOAD: tx_data = next ciphertext byte (MSB first), tx_start pulse, then TX_WAIT.
- TX_WAIT: on tx_done, return to TX_LOAD, or to IDLE after the 16th byte.
- Inter-byte timeout:
  - Counter clears on each rx_done and while in IDLE.
  - If it reaches RX_TIMEOUT in RX_KEY or RX_PT, go to IDLE.
  - The partial frame is discarded; new_key and pt_to_aes are unchanged.
- rx_done in any state other than IDLE, RX_KEY or RX_PT is dropped (the host must respect busy).
- tx_done is ignored outside ACK and TX_WAIT.
- WAIT has no timeout; only reset leaves it.

## Timing
- All outputs are registered.
- Reset values (reset == 0 at a clk edge):
  - state IDLE; tx_data, tx_start, aes_start, key_write_en, busy and trigger all 0.
  - pt_to_aes and new_key 128'h0; byte_cnt and timeout counter 0.
- Reset mid-operation: the next edge returns to IDLE with the reset values above.
  - A byte already in flight in the UART transmitter completes, but its tx_done is ignored.
- Latencies:
  - 16th key rx_done → key_write_en: 1 cycle.
  - 16th plaintext rx_done → aes_start: 1 cycle.
  - aes_ready sampled → first tx_start: 2 cycles.
  - tx_done → next tx_start: 1 cycle.
- tx_start is never high in the same cycle as, or while waiting for, an outstanding tx_done.
- Exactly one aes_start per 'P' frame and exactly 16 tx_start pulses per encryption.

## Configuration
- SCA_TRIGGER_EN defined:
  - trigger goes high in the cycle aes_start is high.
  - It stays high through WAIT and falls in the cycle after aes_ready is latched.
- SCA_TRIGGER_EN undefined:
  - trigger is tied to 0 and the trigger register is not synthesized.
  - All other behaviour is identical.

## Test plan
- Key load: 'K' followed by 16×8'h00.
  - key_write_en pulses once; new_key = 128'h0.
  - One tx_start with tx_data = 8'h06; busy returns to 0 after tx_done.
- Encrypt: 'P' followed by DE AD BE EF ×4; AES model asserts aes_ready 20 cycles later with ct = 128'hdeadbeef×4.
  - pt_to_aes = 128'hdeadbeefdeadbeefdeadbeefdeadbeef.
  - aes_start pulses once, 1 cycle after the 16th rx_done.
  - 16 transmitted bytes DE AD BE EF … in order.
- Junk and timeout: 8'h55, then 'P' + 5 bytes, then silence for RX_TIMEOUT+1 cycles.
  - No aes_start; busy = 0; pt_to_aes unchanged.
  - A following full 'P' + FF 00 ×8 frame encrypts normally.
- Reset mid-transmit: assert reset after the 4th ciphertext tx_start.
  - All outputs return to their reset values on the next edge.
  - Later tx_done pulses cause no tx_start.
- Trigger, built with SCA_TRIGGER_EN: trigger high from the aes_start cycle until one cycle after aes_ready is sampled. Rebuilt without the macro: trigger stays 0 for the whole encrypt test.
- Dropped input: rx_done pulses during WAIT and TX_WAIT do not alter state, byte_cnt or the transmitted ciphertext.
